y86_regfile_mp: RTL and testbench

Parametrised multi-port register file for the Y86-64 SEQ/PIPE datapath, replacing the fixed 15-entry decode/write-back register block. It provides two combinational read ports (srcA/srcB) and two clocked write ports (dstE/dstM) with deterministic same-cycle priority. It adds optional write-to-read bypass, a stall input, and a handshaked serial dump port that streams a coherent snapshot of the whole register file to the testbench or debug logic. It sits between the decode stage (reads) and the write-back stage (writes).

---
 rtl/y86_pkg.sv | 51 +++++
 rtl/y86_rf_dump.sv | 92 +++++++++
 rtl/y86_regfile_mp.sv | 103 ++++++++++
 tb/tb_y86_regfile_mp.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: register indices, instruction codes and the
// dump FSM state type used by the register file and its callers.
package y86_pkg;

    // Register index meaning "no register" on read and write ports.
    localparam logic [3:0] RNONE = 4'hF;

    // Architectural register indices.
    localparam logic [3:0] RRAX = 4'h0;
    localparam logic [3:0] RRCX = 4'h1;
    localparam logic [3:0] RRDX = 4'h2;
    localparam logic [3:0] RRBX = 4'h3;
    localparam logic [3:0] RSP  = 4'h4;
    localparam logic [3:0] RRBP = 4'h5;
    localparam logic [3:0] RRSI = 4'h6;
    localparam logic [3:0] RRDI = 4'h7;
    localparam logic [3:0] RR8  = 4'h8;
    localparam logic [3:0] RR9  = 4'h9;
    localparam logic [3:0] RR10 = 4'hA;
    localparam logic [3:0] RR11 = 4'hB;
    localparam logic [3:0] RR12 = 4'hC;
    localparam logic [3:0] RR13 = 4'hD;
    localparam logic [3:0] RR14 = 4'hE;

    // Instruction codes used by the decode / write-back stages to choose
    // srcA/srcB/dstE/dstM.
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Dump engine states.
    typedef enum logic {
        DUMP_IDLE = 1'b0,
        DUMP_SEND = 1'b1
    } dump_state_t;

    // True when a (zero-extended) register index addresses a real register.
    function automatic logic idx_valid(input logic [31:0] idx, input int nregs);
        return idx < nregs;
    endfunction

endpackage

// File: rtl/y86_rf_dump.sv
// Snapshot dump engine: captures the whole register file in one cycle and
// streams it out one word per accepted handshake, independent of later writes.
module y86_rf_dump
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] live_next [NREGS],
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    dump_state_t       state_reg;
    logic [DATA_W-1:0] snap_reg [NREGS];
    logic [ADDR_W-1:0] idx_reg;
    logic [DATA_W-1:0] data_reg;
    logic              valid_reg;
    logic              done_reg;
    logic              capture;
    logic              accept;

    // A start is honoured only while idle; ready only matters while sending.
    assign capture = (state_reg == DUMP_IDLE) && dump_start;
    assign accept  = (state_reg == DUMP_SEND) && valid_reg && dump_ready;

    // Snapshot takes the post-write array so a same-edge write is included.
    always_ff @(posedge clk) begin
        if (!reset && capture) begin
            for (int i = 0; i < NREGS; i++) begin
                snap_reg[i] <= live_next[i];
            end
        end
    end

    // Dump FSM with registered handshake outputs; dump_data is read from the
    // snapshot one word ahead so no path exists from dump_ready to outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= DUMP_IDLE;
            idx_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                DUMP_IDLE: begin
                    if (capture) begin
                        state_reg <= DUMP_SEND;
                        idx_reg   <= '0;
                        data_reg  <= live_next[0];
                        valid_reg <= 1'b1;
                    end
                end
                DUMP_SEND: begin
                    if (accept) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= DUMP_IDLE;
                            idx_reg   <= '0;
                            data_reg  <= '0;
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            idx_reg  <= idx_reg + 1'b1;
                            data_reg <= snap_reg[idx_reg + 1'b1];
                        end
                    end
                end
                default: begin
                    state_reg <= DUMP_IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign dump_valid = valid_reg;
    assign dump_idx   = idx_reg;
    assign dump_data  = data_reg;
    assign dump_done  = done_reg;

endmodule

// File: rtl/y86_regfile_mp.sv
// Y86-64 register file: two combinational read ports with optional write
// bypass, two clocked write ports (dstM wins on collision), stall, and a
// snapshot dump port.
module y86_regfile_mp
    import y86_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                NREGS    = 15,
    parameter int                ADDR_W   = 4,
    parameter int                BYPASS   = 1,
    parameter logic [DATA_W-1:0] RESET_SP = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              stall,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    logic [DATA_W-1:0] regs_reg  [NREGS];
    logic [DATA_W-1:0] regs_next [NREGS];
    logic              src_a_ok;
    logic              src_b_ok;

    // Per-register next value: dstM checked first so popq %rsp keeps valM.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_next
            assign regs_next[gi] =
                (!stall && (dstM == ADDR_W'(gi))) ? valM :
                (!stall && (dstE == ADDR_W'(gi))) ? valE :
                regs_reg[gi];
        end
    endgenerate

    // Array update; reset overrides any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= (i == int'(RSP)) ? RESET_SP : '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= regs_next[i];
            end
        end
    end

    assign src_a_ok = idx_valid(32'(srcA), NREGS);
    assign src_b_ok = idx_valid(32'(srcB), NREGS);

    // Read port A: out-of-range index reads zero, bypass gives dstM priority.
    always_comb begin
        valA = '0;
        if (src_a_ok) begin
            valA = regs_reg[srcA];
            if ((BYPASS != 0) && !stall) begin
                if (srcA == dstE) valA = valE;
                if (srcA == dstM) valA = valM;
            end
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        valB = '0;
        if (src_b_ok) begin
            valB = regs_reg[srcB];
            if ((BYPASS != 0) && !stall) begin
                if (srcB == dstE) valB = valE;
                if (srcB == dstM) valB = valM;
            end
        end
    end

    y86_rf_dump #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_dump (
        .clk        (clk),
        .reset      (reset),
        .live_next  (regs_next),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

endmodule

// File: tb/tb_y86_regfile_mp.sv
// Scoreboard bench for y86_regfile_mp: read expectations and dump words are
// queued when stimulus is driven and compared when the DUT presents them.
module tb_y86_regfile_mp;
    import y86_pkg::*;

    localparam int          DW  = 64;
    localparam int          NR  = 15;
    localparam int          AW  = 4;
    localparam logic [63:0] SP0 = 64'h200;

    localparam int SEL_A    = 0;
    localparam int SEL_B    = 1;
    localparam int SEL_A_NB = 2;
    localparam int SEL_B_NB = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] srcA, srcB, dstE, dstM;
    logic [DW-1:0] valA, valB, valE, valM;
    logic [DW-1:0] valA_nb, valB_nb;
    logic          stall;
    logic          dump_start, dump_valid, dump_ready, dump_done;
    logic [AW-1:0] dump_idx;
    logic [DW-1:0] dump_data;
    logic          nb_dump_valid, nb_dump_done;
    logic [AW-1:0] nb_dump_idx;
    logic [DW-1:0] nb_dump_data;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] val;
    } sb_t;

    typedef struct {
        logic [3:0]  idx;
        logic [63:0] data;
    } dw_t;

    sb_t         sb_q[$];
    dw_t         dq[$];
    logic [63:0] mdl [NR];
    int          errors = 0;
    int          checks = 0;
    int          done_cnt;
    bit          reached;

    always #5 clk = ~clk;

    y86_regfile_mp #(
        .DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .BYPASS(1), .RESET_SP(SP0)
    ) dut (
        .clk(clk), .reset(reset),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
        .stall(stall),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done)
    );

    y86_regfile_mp #(
        .DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .BYPASS(0), .RESET_SP(SP0)
    ) dut_nb (
        .clk(clk), .reset(reset),
        .srcA(srcA), .srcB(srcB), .valA(valA_nb), .valB(valB_nb),
        .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
        .stall(stall),
        .dump_start(1'b0), .dump_valid(nb_dump_valid), .dump_ready(1'b0),
        .dump_idx(nb_dump_idx), .dump_data(nb_dump_data), .dump_done(nb_dump_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [63:0] val);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    // Let combinational reads settle, then compare every queued expectation.
    task automatic drain();
        sb_t         e;
        logic [63:0] got;
        #2;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                SEL_A:    got = valA;
                SEL_B:    got = valB;
                SEL_A_NB: got = valA_nb;
                default:  got = valB_nb;
            endcase
            check(e.tag, got, e.val);
            $display("read %s: %h", e.tag, got);
        end
    endtask

    task automatic idle_writes();
        dstE  = RNONE;
        dstM  = RNONE;
        valE  = '0;
        valM  = '0;
        stall = 1'b0;
    endtask

    // Advance one clock, applying the architectural write rules to the model.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NR; i++) mdl[i] = '0;
            mdl[4] = SP0;
        end else if (!stall) begin
            if (dstE < NR) mdl[dstE] = valE;
            if (dstM < NR) mdl[dstM] = valM;
        end
        #1;
    endtask

    task automatic push_snapshot();
        dw_t w;
        for (int i = 0; i < NR; i++) begin
            w.idx  = 4'(i);
            w.data = mdl[i];
            dq.push_back(w);
        end
    endtask

    task automatic accept_word(input string tag);
        dw_t w;
        if (dq.size() == 0) begin
            check({tag, "_extra"}, 64'(dump_idx), 64'hFFFF);
        end else begin
            w = dq.pop_front();
            $display("dump word idx=%0d data=%h", dump_idx, dump_data);
            check({tag, "_idx"}, 64'(dump_idx), 64'(w.idx));
            check({tag, "_data"}, dump_data, w.data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        srcA       = '0;
        srcB       = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        idle_writes();
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        // Write presented during reset must be discarded.
        dstE = 4'd1;
        valE = 64'd77;
        tick();
        tick();
        reset = 1'b0;
        idle_writes();

        // Reset state of every register and of the dump port.
        for (int i = 0; i < NR; i++) begin
            srcA = 4'(i);
            srcB = 4'(NR - 1 - i);
            expect_val($sformatf("rst_a%0d", i), SEL_A, (i == 4) ? SP0 : 64'h0);
            expect_val($sformatf("rst_b%0d", NR - 1 - i), SEL_B, (NR - 1 - i == 4) ? SP0 : 64'h0);
            drain();
            tick();
        end
        check("rst_dvalid", 64'(dump_valid), 64'h0);
        check("rst_ddone", 64'(dump_done), 64'h0);
        check("rst_didx", 64'(dump_idx), 64'h0);
        check("rst_ddata", dump_data, 64'h0);

        // Same-cycle collision on reg 3: valM wins, also through the bypass.
        dstE = 4'd3; valE = 64'd5; dstM = 4'd3; valM = 64'd9;
        srcA = 4'd3;
        expect_val("coll_byp_a", SEL_A, 64'd9);
        expect_val("coll_nb_a", SEL_A_NB, 64'd0);
        drain();
        tick();
        idle_writes();
        expect_val("coll_st_a", SEL_A, 64'd9);
        expect_val("coll_st_nb", SEL_A_NB, 64'd9);
        drain();
        tick();

        // Independent E and M bypass on different registers.
        dstE = 4'd6; valE = 64'h66; dstM = 4'd7; valM = 64'h77;
        srcA = 4'd6; srcB = 4'd7;
        expect_val("bypE_a", SEL_A, 64'h66);
        expect_val("bypM_b", SEL_B, 64'h77);
        expect_val("bypE_nb", SEL_A_NB, 64'h0);
        expect_val("bypM_nb", SEL_B_NB, 64'h0);
        drain();
        tick();

        // Stall suppresses both the write and the bypass.
        idle_writes();
        dstE = 4'd2; valE = 64'h22;
        tick();
        stall = 1'b1; dstE = 4'd2; valE = 64'd7; srcB = 4'd2;
        expect_val("stall_b", SEL_B, 64'h22);
        expect_val("stall_nb", SEL_B_NB, 64'h22);
        drain();
        tick();
        idle_writes();
        expect_val("stall_after", SEL_B, 64'h22);
        drain();
        tick();

        // RNONE on reads and writes.
        dstE = RNONE; valE = 64'hDEAD; dstM = RNONE; valM = 64'hBEEF;
        srcA = RNONE; srcB = RNONE;
        expect_val("rnone_a", SEL_A, 64'h0);
        expect_val("rnone_b", SEL_B, 64'h0);
        drain();
        tick();
        idle_writes();
        for (int i = 0; i < NR; i++) begin
            srcA = 4'(i);
            expect_val($sformatf("rnone_r%0d", i), SEL_A, mdl[i]);
            drain();
            tick();
        end

        // Fill reg i = i*16, leaving reg 14 to be written on the start edge.
        for (int i = 0; i < NR; i++) begin
            dstE = 4'(i);
            valE = (i == NR - 1) ? 64'h0 : 64'(i * 16);
            tick();
        end
        idle_writes();
        dump_start = 1'b1;
        dstM = 4'd14; valM = 64'hE0;
        for (int i = 0; i < NR; i++) begin
            dw_t w;
            w.idx  = 4'(i);
            w.data = 64'(i * 16);
            dq.push_back(w);
        end
        tick();
        dump_start = 1'b0;
        idle_writes();
        check("d1_first_valid", 64'(dump_valid), 64'h1);

        // Toggle ready, retrigger start (ignored) and write live during SEND.
        done_cnt = 0;
        for (int c = 0; c < 100 && dq.size() > 0; c++) begin
            dump_ready = (c % 2 == 0);
            dump_start = (c >= 2 && c < 5);
            dstE = (c == 3) ? 4'd13 : RNONE;
            valE = 64'hBAD;
            @(negedge clk);
            if (dump_done) done_cnt++;
            if (dump_valid && dump_ready) accept_word("d1");
            tick();
        end
        idle_writes();
        dump_start = 1'b0;
        check("d1_left", 64'(dq.size()), 64'h0);
        check("d1_done_early", 64'(done_cnt), 64'h0);
        check("d1_done_pulse", 64'(dump_done), 64'h1);
        check("d1_valid_off", 64'(dump_valid), 64'h0);

        // New start accepted in the dump_done cycle.
        dump_start = 1'b1;
        dump_ready = 1'b1;
        push_snapshot();
        tick();
        dump_start = 1'b0;
        check("d2_done_clear", 64'(dump_done), 64'h0);
        check("d2_valid", 64'(dump_valid), 64'h1);

        // Overwrite reg 5 during SEND, then reset when word 7 is presented.
        reached = 1'b0;
        for (int c = 0; c < 40; c++) begin
            dstE = (c == 1) ? 4'd5 : RNONE;
            valE = 64'd99;
            @(negedge clk);
            if (dump_idx == 4'd7) begin
                reached = 1'b1;
                break;
            end
            if (dump_valid && dump_ready) accept_word("d2");
            tick();
        end
        check("d2_reached7", 64'(reached), 64'h1);
        idle_writes();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dq.delete();
        check("abort_valid", 64'(dump_valid), 64'h0);
        check("abort_done", 64'(dump_done), 64'h0);
        check("abort_idx", 64'(dump_idx), 64'h0);
        check("abort_data", dump_data, 64'h0);
        tick();
        check("abort_done2", 64'(dump_done), 64'h0);
        check("abort_valid2", 64'(dump_valid), 64'h0);
        srcA = 4'd5; srcB = 4'd4;
        expect_val("post_rst_r5", SEL_A, 64'h0);
        expect_val("post_rst_sp", SEL_B, SP0);
        drain();
        tick();

        check("nb_dvalid", 64'(nb_dump_valid), 64'h0);
        check("nb_ddone", 64'(nb_dump_done), 64'h0);
        check("nb_didx", 64'(nb_dump_idx), 64'h0);
        check("nb_ddata", nb_dump_data, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
